instr_loader: RTL and testbench

- Writer side of the instruction-memory interface.
- Accepts symbolic instruction requests (operation class plus register/immediate/target fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word using the same opcode/funct set the CPU's main control decodes, and writes it sequentially into instruction memory from a base address.
- Used by testbenches and boot logic to load programs before the single-cycle CPU is released from reset.

---
 rtl/instr_loader_pkg.sv | 44 ++++
 rtl/instr_loader_encode.sv | 33 +++
 rtl/instr_loader.sv | 133 +++++++++++++
 tb/tb_instr_loader.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared encodings for the instruction loader and the CPU control decoders.
// Holds MIPS opcode/funct values, the request op-class enum and loader states.
package instr_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    CLS_ADD = 4'd0,
    CLS_SUB = 4'd1,
    CLS_AND = 4'd2,
    CLS_OR  = 4'd3,
    CLS_SLT = 4'd4,
    CLS_LW  = 4'd5,
    CLS_SW  = 4'd6,
    CLS_BEQ = 4'd7,
    CLS_J   = 4'd8
  } op_cls_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } ld_state_e;

  function automatic logic [31:0] r_word(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/instr_loader_encode.sv
// Combinational encoder: symbolic op class plus fields -> 32-bit MIPS word.
// Op classes 9-15 produce a zero word with illegal_o raised.
module instr_encode
  import instr_loader_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unique case (op_i)
      CLS_ADD: word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      CLS_SUB: word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      CLS_AND: word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
      CLS_OR:  word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
      CLS_SLT: word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      CLS_LW:  word_o = {OP_LW, rs_i, rt_i, imm_i};
      CLS_SW:  word_o = {OP_SW, rs_i, rt_i, imm_i};
      CLS_BEQ: word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      CLS_J:   word_o = {OP_J, target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction-memory writer fed by a valid/ready request stream.
// Define LOADER_CHECKSUM_EN to add a running XOR checksum output.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
`ifdef LOADER_CHECKSUM_EN
  ,output logic [31:0]      checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic              ill_q;
  logic              full_err_q;
  logic [31:0]       cks_q;

  logic [31:0] enc_word;
  logic        enc_ill;
  logic        full;
  logic        hs;
  logic        open_s;

  instr_encode u_enc (
    .op_i      (op),
    .rs_i      (rs),
    .rt_i      (rt),
    .rd_i      (rd),
    .imm_i     (imm),
    .target_i  (target),
    .word_o    (enc_word),
    .illegal_o (enc_ill)
  );

  // Full once every word of the memory has been written this session.
  assign full     = count_q[ADDR_W];
  assign in_ready = (state_q == S_LOAD) & ~full;
  assign hs       = in_valid & in_ready;
  assign open_s   = (state_q == S_IDLE) & start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (hs && in_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= BASE;
      addr_q     <= BASE;
      wdata_q    <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      full_err_q <= 1'b0;
      cks_q      <= '0;
    end else begin
      we_q <= 1'b0;
      if (open_s) begin
        ptr_q      <= BASE;
        count_q    <= '0;
        ill_q      <= 1'b0;
        full_err_q <= 1'b0;
        cks_q      <= '0;
      end
      if (hs && enc_ill) begin
        ill_q <= 1'b1;
      end else if (hs) begin
        we_q    <= 1'b1;
        addr_q  <= ptr_q;
        wdata_q <= enc_word;
        ptr_q   <= ptr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W+1)'(1);
        cks_q   <= cks_q ^ enc_word;
      end
      if ((state_q == S_LOAD) && full && in_valid)
        full_err_q <= 1'b1;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign busy        = (state_q == S_LOAD);
  assign done        = (state_q == S_DONE);
  assign err_illegal = ill_q;
  assign err_full    = full_err_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum    = cks_q;
`else
  logic unused_cks;
  assign unused_cks = ^cks_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: default-size and ADDR_W=2 instances.
// Expected words come from a behavioural encoder built on plain arithmetic.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] tgt = '0;

  logic        rdy_a, we_a, busy_a, done_a, ill_a, full_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a;
  logic [8:0]  cnt_a;
  logic        rdy_b, we_b, busy_b, done_b, ill_b, full_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  cnt_b;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cks_a, cks_b;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start_a),
    .in_valid(in_valid), .in_ready(rdy_a), .in_last(in_last),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(tgt),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
    .count(cnt_a), .busy(busy_a), .done(done_a),
    .err_illegal(ill_a), .err_full(full_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(start_b),
    .in_valid(in_valid), .in_ready(rdy_b), .in_last(in_last),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(tgt),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
    .count(cnt_b), .busy(busy_b), .done(done_b),
    .err_illegal(ill_b), .err_full(full_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

  function automatic logic [31:0] ref_enc(
    input int op_v, input int rs_v, input int rt_v, input int rd_v,
    input int imm_v, input int tgt_v, output bit ill
  );
    longint w;
    longint fn;
    longint opc;
    ill = 1'b0;
    w = 0;
    fn = 0;
    opc = 0;
    case (op_v)
      0: fn = 32;
      1: fn = 34;
      2: fn = 36;
      3: fn = 37;
      4: fn = 42;
      5: opc = 35;
      6: opc = 43;
      7: opc = 4;
      8: opc = 2;
      default: ill = 1'b1;
    endcase
    if (op_v <= 4)
      w = rs_v * 2097152 + rt_v * 65536 + rd_v * 2048 + fn;
    else if (op_v <= 7)
      w = opc * 67108864 + rs_v * 2097152 + rt_v * 65536 + imm_v;
    else if (op_v == 8)
      w = opc * 67108864 + tgt_v;
    return 32'(w);
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int o, input int s, input int t, input int d,
                       input int i, input int g, input bit l);
    in_valid = 1'b1;
    op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d);
    imm = 16'(i); tgt = 26'(g); in_last = l;
  endtask

  task automatic idle_in;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic open_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({we_a, busy_a, done_a, ill_a, full_a, rdy_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=000000",
               {we_a, busy_a, done_a, ill_a, full_a, rdy_a});
    end
    n_chk++;
    if (addr_a !== 8'd0 || wd_a !== 32'd0 || cnt_a !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%0d wd=%h cnt=%0d exp 0/0/0",
               addr_a, wd_a, cnt_a);
    end
    n_chk++;
    if ({we_b, busy_b, done_b, rdy_b} !== 4'b0 || cnt_b !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_small got=%b cnt=%0d exp 0",
               {we_b, busy_b, done_b, rdy_b}, cnt_b);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single;
    do_reset();
    open_a();
    n_chk++;
    if (busy_a !== 1'b1 || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_load got busy=%b rdy=%b exp 1 1", busy_a, rdy_a);
    end
    drive(0, 1, 2, 3, 0, 0, 1'b0);
    step();
    idle_in();
    n_chk++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wd_a !== 32'h00221820
        || cnt_a !== 9'd1) begin
      n_fail++;
      $display("FAIL single_add got we=%b a=%0d d=%h c=%0d exp 1 0 00221820 1",
               we_a, addr_a, wd_a, cnt_a);
    end
    step();
    n_chk++;
    if (we_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle got we=%b busy=%b exp 0 1", we_a, busy_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [4];
    int ndone;
    exp_w[0] = 32'h8D280004;
    exp_w[1] = 32'hAD280004;
    exp_w[2] = 32'h1022FFFF;
    exp_w[3] = 32'h08000010;
    ndone = 0;
    do_reset();
    open_a();
    for (int k = 0; k < 7; k++) begin
      if (k >= 1 && k <= 4) begin
        n_chk++;
        if (we_a !== 1'b1 || addr_a !== 8'(k - 1) || wd_a !== exp_w[k-1]) begin
          n_fail++;
          $display("FAIL b2b_word%0d got we=%b a=%0d d=%h exp 1 %0d %h",
                   k - 1, we_a, addr_a, wd_a, k - 1, exp_w[k-1]);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (cnt_a !== 9'd4 || done_a !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_end got cnt=%0d done=%b exp 4 1", cnt_a, done_a);
        end
`ifdef LOADER_CHECKSUM_EN
        n_chk++;
        if (cks_a !== (exp_w[0] ^ exp_w[1] ^ exp_w[2] ^ exp_w[3])) begin
          n_fail++;
          $display("FAIL b2b_checksum got=%h exp=%h", cks_a,
                   exp_w[0] ^ exp_w[1] ^ exp_w[2] ^ exp_w[3]);
        end
`endif
      end
      if (k == 6) begin
        n_chk++;
        if (busy_a !== 1'b0 || we_a !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle got busy=%b we=%b exp 0 0", busy_a, we_a);
        end
      end
      ndone += int'(done_a);
      case (k)
        0: drive(5, 9, 8, 0, 4, 0, 1'b0);
        1: drive(6, 9, 8, 0, 4, 0, 1'b0);
        2: drive(7, 1, 2, 0, 16'hFFFF, 0, 1'b0);
        3: drive(8, 0, 0, 0, 0, 26'h10, 1'b1);
        default: idle_in();
      endcase
      step();
    end
    n_chk++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL b2b_done_pulses got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_gaps;
    int exp_ptr, exp_cnt, pend_a;
    bit exp_ill, pend, ill, v;
    int o, s, t, d, i, g;
    logic [31:0] w, pend_d;
    exp_ptr = 0; exp_cnt = 0; exp_ill = 0; pend = 0;
    pend_a = 0; pend_d = '0;
    do_reset();
    open_a();
    for (int k = 0; k <= 40; k++) begin
      n_chk++;
      if (pend && (we_a !== 1'b1 || addr_a !== 8'(pend_a) || wd_a !== pend_d)) begin
        n_fail++;
        $display("FAIL gaps_write k=%0d got we=%b a=%0d d=%h exp 1 %0d %h",
                 k, we_a, addr_a, wd_a, pend_a, pend_d);
      end else if (!pend && we_a !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps_nowrite k=%0d got we=%b exp 0", k, we_a);
      end
      n_chk++;
      if (cnt_a !== 9'(exp_cnt) || ill_a !== exp_ill) begin
        n_fail++;
        $display("FAIL gaps_state k=%0d got cnt=%0d ill=%b exp %0d %b",
                 k, cnt_a, ill_a, exp_cnt, exp_ill);
      end
      if (k == 40) begin
        n_chk++;
        if (done_a !== 1'b1) begin
          n_fail++;
          $display("FAIL gaps_done got=%b exp=1", done_a);
        end
        break;
      end
      n_chk++;
      if (rdy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL gaps_ready k=%0d got=%b exp=1", k, rdy_a);
      end
      v = (k == 39) ? 1'b1 : 1'($urandom_range(0, 1));
      o = $urandom_range(0, 10);
      s = $urandom_range(0, 31); t = $urandom_range(0, 31);
      d = $urandom_range(0, 31); i = $urandom_range(0, 65535);
      g = $urandom_range(0, 67108863);
      pend = 0;
      if (v) begin
        drive(o, s, t, d, i, g, k == 39);
        w = ref_enc(o, s, t, d, i, g, ill);
        if (ill) exp_ill = 1;
        else begin
          pend = 1; pend_a = exp_ptr; pend_d = w;
          exp_ptr++; exp_cnt++;
        end
      end else begin
        idle_in();
      end
      step();
    end
    idle_in();
    step();
  endtask

  task automatic test_illegal;
    bit ill;
    logic [31:0] w0, w1;
    w0 = ref_enc(0, 1, 2, 3, 0, 0, ill);
    w1 = ref_enc(3, 4, 5, 6, 0, 0, ill);
    do_reset();
    open_a();
    drive(0, 1, 2, 3, 0, 0, 1'b0);
    step();
    n_chk++;
    if (we_a !== 1'b1 || addr_a !== 8'd0 || wd_a !== w0) begin
      n_fail++;
      $display("FAIL ill_first got we=%b a=%0d d=%h exp 1 0 %h",
               we_a, addr_a, wd_a, w0);
    end
    drive(12, 7, 7, 7, 7, 7, 1'b0);
    step();
    n_chk++;
    if (we_a !== 1'b0 || ill_a !== 1'b1 || cnt_a !== 9'd1) begin
      n_fail++;
      $display("FAIL ill_skip got we=%b ill=%b cnt=%0d exp 0 1 1",
               we_a, ill_a, cnt_a);
    end
    drive(3, 4, 5, 6, 0, 0, 1'b0);
    step();
    n_chk++;
    if (we_a !== 1'b1 || addr_a !== 8'd1 || wd_a !== w1 || cnt_a !== 9'd2) begin
      n_fail++;
      $display("FAIL ill_next got we=%b a=%0d d=%h c=%0d exp 1 1 %h 2",
               we_a, addr_a, wd_a, cnt_a, w1);
    end
    drive(13, 0, 0, 0, 0, 0, 1'b1);
    step();
    idle_in();
    n_chk++;
    if (we_a !== 1'b0 || done_a !== 1'b1 || ill_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_last got we=%b done=%b ill=%b exp 0 1 1",
               we_a, done_a, ill_a);
    end
    step();
    open_a();
    n_chk++;
    if (ill_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 9'd0) begin
      n_fail++;
      $display("FAIL ill_clear got ill=%b busy=%b cnt=%0d exp 0 1 0",
               ill_a, busy_a, cnt_a);
    end
  endtask

  task automatic test_full;
    logic [31:0] ew [5];
    int o [5];
    bit ill;
    do_reset();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      o[k] = $urandom_range(0, 8);
      ew[k] = ref_enc(o[k], k + 1, k + 2, k + 3, k * 100, k * 1000, ill);
    end
    for (int k = 0; k < 9; k++) begin
      if (k >= 1 && k <= 4) begin
        n_chk++;
        if (we_b !== 1'b1 || addr_b !== 2'(k - 1) || wd_b !== ew[k-1]) begin
          n_fail++;
          $display("FAIL full_write%0d got we=%b a=%0d d=%h exp 1 %0d %h",
                   k - 1, we_b, addr_b, wd_b, k - 1, ew[k-1]);
        end
      end else if (k >= 5) begin
        n_chk++;
        if (we_b !== 1'b0) begin
          n_fail++;
          $display("FAIL full_overwrite k=%0d got we=%b a=%0d exp we=0",
                   k, we_b, addr_b);
        end
      end
      if (k == 2) begin
        n_chk++;
        if (full_b !== 1'b0 || rdy_b !== 1'b1) begin
          n_fail++;
          $display("FAIL full_early got err=%b rdy=%b exp 0 1", full_b, rdy_b);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (rdy_b !== 1'b0 || cnt_b !== 3'd4) begin
          n_fail++;
          $display("FAIL full_ready got rdy=%b cnt=%0d exp 0 4", rdy_b, cnt_b);
        end
      end
      if (k == 6) begin
        n_chk++;
        if (full_b !== 1'b1 || busy_b !== 1'b1 || done_b !== 1'b0) begin
          n_fail++;
          $display("FAIL full_err got err=%b busy=%b done=%b exp 1 1 0",
                   full_b, busy_b, done_b);
        end
      end
      if (k < 6) drive(o[k < 5 ? k : 4], k + 1, k + 2, k + 3, k * 100,
                       k * 1000, k >= 4);
      else idle_in();
      step();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    open_a();
    drive(1, 3, 4, 5, 0, 0, 1'b0);
    step();
    drive(2, 6, 7, 8, 0, 0, 1'b0);
    step();
    idle_in();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({we_a, busy_a, done_a, ill_a, full_a, rdy_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags got=%b exp=000000",
               {we_a, busy_a, done_a, ill_a, full_a, rdy_a});
    end
    n_chk++;
    if (addr_a !== 8'd0 || wd_a !== 32'd0 || cnt_a !== 9'd0) begin
      n_fail++;
      $display("FAIL mid_reset_data got a=%0d d=%h c=%0d exp 0 0 0",
               addr_a, wd_a, cnt_a);
    end
`ifdef LOADER_CHECKSUM_EN
    n_chk++;
    if (cks_a !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_checksum got=%h exp=0", cks_a);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    n_chk++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_after got done=%b busy=%b exp 0 0",
               done_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_illegal();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
